req_arbiter_4: RTL and testbench
================================

Name: req_arbiter_4

Overview:
- Four-requester bus arbiter built around the four-input priority-encoding scheme used in this design.
- Shares one resource among requesters 0..3.
- Supports fixed priority (requester 0 highest) or round-robin, selected at run time.
- Issues a registered one-hot grant and an encoded grant index, holds the grant until release, and forces release after a programmable hold limit.

Parameters:
- MAX_HOLD, 8, maximum grant cycles before forced release; 0 disables the timeout.
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
- req  in  4  request lines; bit i belongs to requester i and is held high while requesting.
- rr_mode  in  1  0 = fixed priority, 1 = round-robin; sampled only at arbitration points.
- gnt  out  4  one-hot grant, registered.
- gnt_id  out  2  index of the granted requester; valid only when gnt_valid = 1.
- gnt_valid  out  1  high whenever any gnt bit is high.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async, rst_n = 0):
  - gnt = 0, gnt_id = 0, gnt_valid = 0, timeout = 0.
  - state = IDLE, rr_ptr = 0, hold_cnt = 0, mask = 0.
  - Reset mid-grant drops gnt immediately, with no release cycle.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise arbitrate (see Arbitration), load gnt, gnt_id and gnt_valid = 1 on the next edge, clear hold_cnt, and go to GRANT.
  - Latency from req rising to gnt = 1 clock.
- GRANT:
  - gnt is stable; hold_cnt increments by 1 per cycle, starting at 0 in the first grant cycle.
  - If req[gnt_id] == 0: go to RELEASE with mask = 0.
  - Otherwise, if MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1: go to RELEASE, pulse timeout for exactly one cycle (coincident with the first RELEASE cycle), and set mask = onehot(gnt_id).
  - If both conditions hold in the same cycle, the req drop takes precedence: no timeout pulse and mask = 0.
- RELEASE (exactly one cycle):
  - gnt = 0 and gnt_valid = 0.
  - rr_ptr = (gnt_id + 1) mod 4.
  - Arbitrate over req & ~mask.
    - If a winner exists: grant it on the next edge and go to GRANT.
    - Otherwise go to IDLE.
  - The mask is cleared on leaving RELEASE.
  - A timed-out requester that is the sole requester is therefore regranted two cycles after revocation (RELEASE, then IDLE arbitration).
- Arbitration (combinational, shared by IDLE and RELEASE):
  - Fixed priority: lowest index wins, 0 > 1 > 2 > 3.
  - Round-robin: search from rr_ptr upward with wrap 3 -> 0; the first set bit wins.
- Invariants:
  - rr_mode changes during GRANT have no effect until the next arbitration.
  - Requests from non-owners during GRANT are ignored; there is no preemption.
  - gnt is never multi-hot.
  - gnt_valid == |gnt.
  - hold_cnt saturates; it is never compared when MAX_HOLD == 0.
  - Minimum gap between consecutive grants is 1 cycle (the RELEASE cycle).

Decomposition:
- Shared package (arb_pkg):
  - state encoding constants: IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2;
  - NUM_REQ = 4;
  - the default MAX_HOLD.
- One natural sub-module, prio_pick_4:
  - combinational; inputs req_m[3:0], start[1:0], rr;
  - outputs win_onehot[3:0], win_id[1:0], any.
  - In fixed mode it uses start = 0.
  - Instantiated once and reused by IDLE and RELEASE.

Test Plan:
- Reset: assert rst_n = 0 mid-GRANT with gnt = 4'b0100 -> gnt = 0, gnt_valid = 0, timeout = 0 immediately, without waiting for clk.
- Fixed priority: rr_mode = 0, req = 4'b1110 from IDLE -> next cycle gnt = 4'b0010, gnt_id = 1. Drop req[1] -> one RELEASE cycle with gnt = 0, then gnt = 4'b0100.
- Round-robin rotation: rr_mode = 1, req = 4'b1111 held, each owner drops its req after 2 cycles and reasserts it -> grant order 0, 1, 2, 3, 0 with a 1-cycle gap each.
- Timeout: MAX_HOLD = 8, req = 4'b0011 held constantly, fixed mode -> gnt = 4'b0001 for 8 cycles, then timeout = 1 for one cycle with gnt = 0, then gnt = 4'b0010 (requester 0 masked).
- Sole timed-out requester: req = 4'b0100 held -> 8-cycle grant, timeout pulse, IDLE, regrant 4'b0100 two cycles after revocation.
- Simultaneous events: owner drops req on the cycle where hold_cnt == 7 -> no timeout pulse, normal RELEASE. rr_mode toggled mid-GRANT -> current grant is unaffected.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and sizing for the four-requester arbiter.
// Rev 1.0
`default_nettype none

package arb_pkg;

  localparam int NUM_REQ          = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/req_arbiter_4_prio_pick.sv
// prio_pick_4: combinational 4-way picker; first set bit at or after start (start forced to 0 unless rr).
// Rev 1.0
`default_nettype none

module prio_pick_4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_m,
  input  logic [1:0]         start,
  input  logic               rr,
  output logic [NUM_REQ-1:0] win_onehot,
  output logic [1:0]         win_id,
  output logic               any
);

  logic [1:0] base;
  logic [1:0] idx;

  // Walk from the farthest candidate back to base so the nearest set bit is the last write.
  always_comb begin
    base   = rr ? start : 2'd0;
    idx    = 2'd0;
    win_id = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req_m[idx]) begin
        win_id = idx;
      end
    end
    any        = |req_m;
    win_onehot = any ? (NUM_REQ'(1) << win_id) : '0;
  end

endmodule

`default_nettype wire

// File: rtl/req_arbiter_4.sv
// req_arbiter_4: four-requester arbiter, fixed or round-robin, with hold-limit forced release.
// Rev 1.0
`default_nettype none

module req_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] win_onehot;
  logic [1:0]         win_id;
  logic               win_any;
  logic               owner_req;
  logic               hold_expired;

  // Mask is non-zero only in a RELEASE that followed a timeout.
  assign req_elig     = req & ~mask_q;
  assign owner_req    = req[gnt_id_q];
  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  prio_pick_4 u_pick (
    .req_m      (req_elig),
    .start      (rr_ptr_q),
    .rr         (rr_mode),
    .win_onehot (win_onehot),
    .win_id     (win_id),
    .any        (win_any)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    mask_d     = mask_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        mask_d = '0;
        gnt_d  = '0;
        if (win_any) begin
          gnt_d      = win_onehot;
          gnt_id_d   = win_id;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d  = RELEASE;
          gnt_d    = '0;
          mask_d   = '0;
          rr_ptr_d = gnt_id_q + 2'd1;
        end else if (hold_expired) begin
          state_d   = RELEASE;
          gnt_d     = '0;
          mask_d    = gnt_q;
          rr_ptr_d  = gnt_id_q + 2'd1;
          timeout_d = 1'b1;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        mask_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= 2'd0;
      rr_ptr_q   <= 2'd0;
      hold_cnt_q <= '0;
      mask_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      mask_q     <= mask_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_req_arbiter_4.sv
// tb_req_arbiter_4: directed scenarios plus randomized traffic against a behavioural arbiter model.
// Rev 1.0
`default_nettype none

module tb_req_arbiter_4;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       rr_mode = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who owns the bus, how many cycles it has held it.
  int         m_owner;
  int         m_held;
  int         m_ptr;
  logic [3:0] m_mask;
  logic       m_to;

  req_arbiter_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rr_mode   (rr_mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] elig, input logic rr, input int ptr);
    int first = rr ? ptr : 0;
    for (int k = 0; k < 4; k++) begin
      if (elig[(first + k) % 4]) return (first + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_mask  = 4'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rr);
    int w;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_mask  = 4'b0;
        m_owner = -1;
      end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
        m_ptr   = (m_owner + 1) % 4;
        m_mask  = 4'b0001 << m_owner;
        m_to    = 1'b1;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      w      = pick(r & ~m_mask, rr, m_ptr);
      m_mask = 4'b0;
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end
  endtask

  task automatic compare_model();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0;
    check_eq("gnt", 32'(gnt), 32'(eg));
    check_eq("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check_eq("timeout", 32'(timeout), 32'(m_to));
    if (m_owner >= 0) check_eq("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  task automatic step(input logic [3:0] r, input logic rr);
    @(negedge clk);
    req     = r;
    rr_mode = rr;
    @(posedge clk);
    model_step(r, rr);
    #1;
    compare_model();
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_valid", 32'(gnt_valid), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    check_eq("rst_gnt_id", 32'(gnt_id), 32'h0);
    req = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic       rr;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("init_gnt", 32'(gnt), 32'h0);
    check_eq("init_valid", 32'(gnt_valid), 32'h0);
    rst_n = 1'b1;

    // Fixed priority, then release to next requester.
    step(4'b1110, 1'b0);
    check_eq("fp_gnt", 32'(gnt), 32'h2);
    check_eq("fp_id", 32'(gnt_id), 32'h1);
    step(4'b1100, 1'b0);
    check_eq("fp_gap", 32'(gnt), 32'h0);
    step(4'b1100, 1'b0);
    check_eq("fp_next", 32'(gnt), 32'h4);

    // Reset mid-grant of requester 2.
    async_reset();

    // Round-robin rotation from a fresh pointer.
    for (int g = 0; g < 5; g++) begin
      step(4'b1111, 1'b1);
      check_eq("rr_order", 32'(gnt), 32'(4'b0001 << (g % 4)));
      step(4'b1111, 1'b1);
      step(4'b1111 & ~(4'b0001 << (g % 4)), 1'b1);
    end
    repeat (2) step(4'b0000, 1'b0);

    // Timeout with a competing requester.
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0011, 1'b0);
      check_eq("to_hold", 32'(gnt), 32'h1);
    end
    step(4'b0011, 1'b0);
    check_eq("to_pulse", 32'(timeout), 32'h1);
    check_eq("to_gap", 32'(gnt), 32'h0);
    step(4'b0011, 1'b0);
    check_eq("to_masked", 32'(gnt), 32'h2);
    check_eq("to_single", 32'(timeout), 32'h0);
    repeat (3) step(4'b0000, 1'b0);

    // Sole timed-out requester is regranted two cycles after revocation.
    repeat (MAX_HOLD) step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    check_eq("sole_pulse", 32'(timeout), 32'h1);
    step(4'b0100, 1'b0);
    check_eq("sole_idle", 32'(gnt), 32'h0);
    step(4'b0100, 1'b0);
    check_eq("sole_regnt", 32'(gnt), 32'h4);
    repeat (2) step(4'b0000, 1'b0);

    // Owner drops on the last hold cycle: normal release, no pulse.
    repeat (MAX_HOLD) step(4'b0001, 1'b0);
    step(4'b0000, 1'b0);
    check_eq("simul_to", 32'(timeout), 32'h0);
    check_eq("simul_gnt", 32'(gnt), 32'h0);
    step(4'b0000, 1'b0);

    // rr_mode toggling mid-grant leaves the owner alone.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b1111, 1'b0);
    check_eq("rrtog_gnt", 32'(gnt), 32'h1);
    repeat (2) step(4'b0000, 1'b1);

    // Randomized traffic with sticky requests so long holds and timeouts occur.
    r  = 4'b0;
    rr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(15) == 0) rr = ~rr;
      step(r, rr);
      if ($urandom_range(999) == 0) begin
        async_reset();
        r = 4'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
